// File: rtl/gamepad_pmod_rx.sv
// rtl/gamepad_pmod_rx.sv - Gamepad Pmod serial receiver with frame validation and presence timeout
// Optional: define GAMEPAD_PMOD_RX_DEBOUNCE_EN to commit only two identical consecutive frames.
module gamepad_pmod_rx #(
  parameter int NBITS          = 12,
  parameter int TIMEOUT_CYCLES = 2500000
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_pmod_data,
  input  logic             i_pmod_clk,
  input  logic             i_pmod_latch,
  output logic [NBITS-1:0] o_buttons,
  output logic             o_present,
  output logic             o_frame_strobe,
  output logic             o_frame_error
);

  localparam int CW = $clog2(NBITS + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] FULL_COUNT = CW'(NBITS);
  localparam logic [TW-1:0] TIMEOUT_MAX = TW'(TIMEOUT_CYCLES);

  logic [1:0]       r_data_sync;
  logic [2:0]       r_pclk_sync;
  logic [2:0]       r_latch_sync;
  logic             r_data_d;
  logic             r_pclk_rise;
  logic             r_latch_rise;
  logic [NBITS-1:0] r_shift;
  logic [CW-1:0]    r_count;
  logic [TW-1:0]    r_timeout;

  logic [NBITS-1:0] w_shift;
  logic [CW-1:0]    w_count;
  logic             w_accept;
  logic             w_error;
  logic             w_commit;
  logic             w_all_ones;

  // Shift is applied before the latch is evaluated, so a coincident clock edge counts toward the frame.
  always_comb begin
    w_shift    = r_shift;
    w_count    = r_count;
    if (r_pclk_rise) begin
      w_shift = {r_shift[NBITS-2:0], r_data_d};
      if (r_count != FULL_COUNT) w_count = r_count + CW'(1);
    end
    w_accept   = r_latch_rise && (w_count == FULL_COUNT);
    w_error    = r_latch_rise && (w_count != FULL_COUNT);
    w_all_ones = &w_shift;
  end

`ifdef GAMEPAD_PMOD_RX_DEBOUNCE_EN
  logic [NBITS-1:0] r_prev_frame;

  assign w_commit = w_accept && (w_shift == r_prev_frame);

  always_ff @(posedge i_clk) begin
    if (i_reset) r_prev_frame <= '0;
    else if (w_accept) r_prev_frame <= w_shift;
  end
`else
  assign w_commit = w_accept;
`endif

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_data_sync    <= '0;
      r_pclk_sync    <= '0;
      r_latch_sync   <= '0;
      r_data_d       <= 1'b0;
      r_pclk_rise    <= 1'b0;
      r_latch_rise   <= 1'b0;
      r_shift        <= '0;
      r_count        <= '0;
      r_timeout      <= TIMEOUT_MAX;
      o_buttons      <= '0;
      o_present      <= 1'b0;
      o_frame_strobe <= 1'b0;
      o_frame_error  <= 1'b0;
    end else begin
      r_data_sync  <= {r_data_sync[0], i_pmod_data};
      r_pclk_sync  <= {r_pclk_sync[1:0], i_pmod_clk};
      r_latch_sync <= {r_latch_sync[1:0], i_pmod_latch};
      // Data is delayed alongside the registered edge pulses to stay aligned with them.
      r_data_d     <= r_data_sync[1];
      r_pclk_rise  <= r_pclk_sync[1] & ~r_pclk_sync[2];
      r_latch_rise <= r_latch_sync[1] & ~r_latch_sync[2];

      r_shift <= w_shift;
      r_count <= r_latch_rise ? '0 : w_count;

      o_frame_strobe <= w_commit;
      o_frame_error  <= w_error;

      if (w_accept) r_timeout <= TIMEOUT_MAX;
      else if (r_timeout != '0) r_timeout <= r_timeout - TW'(1);

      if (w_commit) begin
        o_buttons <= w_all_ones ? '0 : w_shift;
        o_present <= ~w_all_ones;
      end else if (!w_accept && r_timeout == TW'(1)) begin
        o_buttons <= '0;
        o_present <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_gamepad_pmod_rx.sv
// tb/tb_gamepad_pmod_rx.sv - scoreboard bench for gamepad_pmod_rx
module tb_gamepad_pmod_rx;

  localparam int T_CYC = 1000;
  localparam int POST  = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        pdata, pclk, platch;
  logic [11:0] buttons;
  logic        present, strobe, ferr;

  gamepad_pmod_rx #(.NBITS(12), .TIMEOUT_CYCLES(T_CYC)) dut (
    .i_clk          (clk),
    .i_reset        (reset),
    .i_pmod_data    (pdata),
    .i_pmod_clk     (pclk),
    .i_pmod_latch   (platch),
    .o_buttons      (buttons),
    .o_present      (present),
    .o_frame_strobe (strobe),
    .o_frame_error  (ferr)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [11:0] btn;
    logic        present;
    logic        err;
  } exp_t;

  exp_t        sb[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [11:0] m_btn = '0;
  logic        m_present = 1'b0;
  logic [11:0] m_prev = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Output monitor: every strobe/error pulse must match the oldest scoreboard entry.
  always @(negedge clk) begin
    if (!reset && (strobe || ferr)) begin
      check("strobe_error_exclusive", {31'd0, strobe & ferr}, 32'd0);
      if (sb.size() == 0) begin
        check("unexpected_pulse", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("pulse_kind_err", {31'd0, ferr}, {31'd0, e.err});
        check("buttons", {20'd0, buttons}, {20'd0, e.btn});
        check("present", {31'd0, present}, {31'd0, e.present});
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic wait_neg(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    pdata = b;
    pclk  = 1'b0;
    wait_neg(4);
    pclk  = 1'b1;
    wait_neg(4);
  endtask

  // Sends n bits MSB-first from bits[n-1], then latches; model pushes the expected pulse.
  task automatic do_frame(input logic [23:0] bits, input int n, input bit simul, input bit chk_lat);
    logic [11:0] frame;
    bit          commit;
    bit          accepted;
    exp_t        e;
    int          nsh;
    nsh = simul ? n - 1 : n;
    for (int i = n - 1; i >= n - nsh; i--) send_bit(bits[i]);
    if (simul) begin
      pdata = bits[0];
      pclk  = 1'b0;
      wait_neg(4);
      pclk   = 1'b1;
      platch = 1'b1;
    end else begin
      pclk = 1'b0;
      wait_neg(4);
      platch = 1'b1;
    end
    accepted = (n >= 12);
    frame    = bits[11:0];
    commit   = 1'b0;
    if (!accepted) begin
      e = '{btn: m_btn, present: m_present, err: 1'b1};
      sb.push_back(e);
    end else begin
`ifdef GAMEPAD_PMOD_RX_DEBOUNCE_EN
      commit = (frame == m_prev);
`else
      commit = 1'b1;
`endif
      m_prev = frame;
      if (commit) begin
        m_btn     = (frame == 12'hFFF) ? 12'h000 : frame;
        m_present = (frame != 12'hFFF);
        e = '{btn: m_btn, present: m_present, err: 1'b0};
        sb.push_back(e);
      end
    end
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (chk_lat && k == 3) check("latency_cycle2_no_strobe", {31'd0, strobe}, 32'd0);
      if (chk_lat && k == 4) check("latency_cycle3_strobe", {31'd0, strobe}, {31'd0, commit});
    end
    platch = 1'b0;
    pclk   = 1'b0;
    wait_neg(POST);
  endtask

  task automatic do_reset();
    pclk   = 1'b0;
    platch = 1'b0;
    reset  = 1'b1;
    wait_neg(3);
    reset  = 1'b0;
    m_btn = '0; m_present = 1'b0; m_prev = '0;
  endtask

  initial begin
    reset = 1'b1; pdata = 1'b0; pclk = 1'b0; platch = 1'b0;
    wait_neg(3);
    reset = 1'b0;
    wait_neg(10);
    check("reset_buttons", {20'd0, buttons}, 32'd0);
    check("reset_present", {31'd0, present}, 32'd0);
    check("reset_strobe", {31'd0, strobe}, 32'd0);
    check("reset_error", {31'd0, ferr}, 32'd0);

    do_frame(24'h000801, 12, 1'b0, 1'b1);
    do_frame(24'hFFF010, 24, 1'b0, 1'b0);
    do_frame(24'h00002A, 7, 1'b0, 1'b0);
    do_frame(24'h000FFF, 12, 1'b0, 1'b0);
    do_frame(24'h0000A5, 12, 1'b1, 1'b0);
    do_frame(24'h000100, 12, 1'b0, 1'b0);
    do_frame(24'h000100, 12, 1'b0, 1'b0);
    do_frame(24'h000200, 12, 1'b0, 1'b0);
    do_frame(24'h000200, 12, 1'b0, 1'b0);
    do_frame(24'h0000C3, 12, 1'b0, 1'b0);
    do_frame(24'h0000C3, 12, 1'b0, 1'b0);

    // Last commit was POST cycles ago; expiry lands T_CYC cycles after it.
    wait_neg(T_CYC - 1 - POST);
    check("timeout_before_present", {31'd0, present}, 32'd1);
    check("timeout_before_buttons", {20'd0, buttons}, 32'h0C3);
    wait_neg(1);
    check("timeout_present", {31'd0, present}, 32'd0);
    check("timeout_buttons", {20'd0, buttons}, 32'd0);
    m_btn = '0; m_present = 1'b0;
    wait_neg(20);
    check("timeout_hold_present", {31'd0, present}, 32'd0);

    do_frame(24'h000801, 12, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) send_bit(1'b1);
    do_reset();
    wait_neg(2);
    check("midreset_buttons", {20'd0, buttons}, 32'd0);
    check("midreset_present", {31'd0, present}, 32'd0);
    do_frame(24'h00007F, 7, 1'b0, 1'b0);
    do_frame(24'h0003C0, 12, 1'b0, 1'b0);
    do_frame(24'h0003C0, 12, 1'b0, 1'b0);

    wait_neg(10);
    check("scoreboard_drained", sb.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/gamepad_pmod_rx.md
# gamepad_pmod_rx

Serial receiver for the Gamepad Pmod: synchronises the three asynchronous Pmod lines (data, clock, latch) into `clk`, deserialises each frame, validates it, and presents a registered 12-bit button vector plus status flags. It sits directly upstream of the VGA display logic, which consumes `buttons` and `present` once per pixel clock.

## Interface
- `NBITS`, 12: bits per controller frame; the last NBITS bits shifted before a latch form the frame.
- `TIMEOUT_CYCLES`, 2500000: `clk` cycles without a latch rising edge before the controller is declared absent (100 ms at 25 MHz).
- `clk`  in  1  pixel clock; sole clock domain.
- `reset`  in  1  synchronous, active-high reset.
- `pmod_data`  in  1  serial button data, asynchronous; 1 = pressed.
- `pmod_clk`  in  1  serial shift clock, asynchronous; data is valid at its rising edge.
- `pmod_latch`  in  1  frame latch, asynchronous; rising edge ends a frame.
- `buttons`  out  12  committed buttons, active-high: [11]=b, [10]=y, [9]=select, [8]=start, [7]=up, [6]=down, [5]=left, [4]=right, [3]=a, [2]=x, [1]=l, [0]=r.
- `present`  out  1  high while a valid, non-all-ones frame is committed and the timeout has not expired.
- `frame_strobe`  out  1  one-cycle pulse when `buttons` is committed.
- `frame_error`  out  1  one-cycle pulse when a latch arrives with fewer than NBITS bits shifted.

## Operation
- Each Pmod input passes through a 2-FF synchroniser, then a third register for edge detection; edges are detected on synchronised signals only.
- Shift register (NBITS): on a `pmod_clk` rising edge, shift left, insert `pmod_data` at bit 0. The first bit transmitted ends at bit NBITS-1 (b). Extra leading bits (chained second controller) fall off the MSB.
- Bit counter: increments per shift, saturates at NBITS, cleared on each latch rising edge.
- On a latch rising edge:
  - count < NBITS: pulse `frame_error`, discard frame; `buttons`, `present` unchanged; timeout counter NOT reloaded.
  - count == NBITS: raw frame accepted; timeout counter reloaded; commit rule below applies.
- Commit: frame == all ones (no controller fitted) -> `buttons`=0, `present`=0; otherwise `buttons`=frame, `present`=1. `frame_strobe` pulses on every commit.
- Timeout counter: counts down each cycle; reaching 0 forces `buttons`=0, `present`=0 and holds at 0 until the next accepted frame. No strobe on timeout.
- Simultaneous `pmod_clk` and latch rising edges in one cycle: the shift is performed first, and the latch evaluates the updated shift register and count.
- Reset mid-frame: shift register, counter and all outputs cleared; the partial frame is lost, and the next latch reports `frame_error` unless NBITS fresh bits arrive.

## Timing
- Reset values: `buttons`=0, `present`=0, `frame_strobe`=0, `frame_error`=0, shift register=0, bit count=0, timeout counter=TIMEOUT_CYCLES.
- Latency: the first `clk` edge that samples `pmod_latch` high is cycle 0. The edge is detected at cycle 2, and `buttons`, `present`, `frame_strobe` and `frame_error` are updated at cycle 3.
- Minimum Pmod clock high/low width: 3 `clk` cycles. Narrower pulses may be missed.
- Outputs are registered and change only on `clk` rising edges; `frame_strobe` and `frame_error` are never high in the same cycle.

## Configuration
- `GAMEPAD_PMOD_RX_DEBOUNCE_EN` defined: an accepted frame commits only if it equals the previous accepted raw frame, which is held in an extra NBITS register. Otherwise only the raw register updates, with no strobe. The timeout still reloads on every accepted frame.
- Undefined: every accepted frame commits immediately; the comparison register is not built.

## Test plan
- Reset, then idle for 10 cycles -> `buttons`=0, `present`=0, no strobes.
- Shift 12'b1000_0000_0001 (b then r pressed), then latch -> 3 cycles after latch sampling, `buttons`=12'h801, `present`=1, single `frame_strobe`.
- Shift 24 bits (12'hFFF then 12'h010), then latch -> `buttons`=12'h010 (right), `present`=1.
- Shift 7 bits, then latch -> `frame_error` pulse; `buttons` keeps its prior value.
- Shift 12'hFFF, then latch -> `buttons`=0, `present`=0, `frame_strobe` pulses. Then a valid frame followed by no latch for TIMEOUT_CYCLES -> `present` falls and `buttons`=0 exactly at expiry.
- With DEBOUNCE_EN: frames 12'h100 then 12'h100 -> commit only on the second. With 12'h100, 12'h200, 12'h200 -> `buttons`=12'h200 only after the third.
